step_seq: RTL and testbench
===========================

# step_seq

Prescaled state sequencer that sits directly upstream of the LED multiplexer stages. It generates the select index that steps a mux through its inputs, plus a one-cycle tick on every advance. It supports free-running mode, single-step mode, up/down direction and a wrap indicator. The index is modulo-N; the advance rate is set by a power-of-two prescaler.

## Interface
- NP, default 22: prescaler width; in run mode the index advances once every 2^NP clock cycles. Range 1..26.
- NSTATES, default 4: number of index states. Range 2..16.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  level; 1 = free-running advance, 0 = stopped or single-step mode.
- dir  in  1  level; 0 = count up, 1 = count down.
- step  in  1  manual advance request; rising-edge detected internally; honoured only when run=0.
- sel  out  4  current index, 0..NSTATES-1; drives the mux select.
- tick  out  1  one-cycle pulse, high in the cycle in which sel shows a newly advanced value.
- wrap  out  1  one-cycle pulse coincident with tick when the advance crossed the boundary (NSTATES-1→0 up, 0→NSTATES-1 down).

## Operation
- Internal state:
  - prescaler counter pc[NP-1:0]
  - step history flop step_q
  - mode FSM with states STOPPED and RUNNING
- FSM transitions:
  - STOPPED→RUNNING when run=1 is sampled.
  - RUNNING→STOPPED when run=0 is sampled.
  - Reset enters STOPPED.
- STOPPED:
  - pc is held at 0.
  - An advance occurs on the edge where step=1 and step_q=0.
- RUNNING:
  - pc increments every cycle.
  - When pc = 2^NP-1, an advance occurs and pc wraps to 0.
  - step is ignored, but step_q still tracks step.
- Entering RUNNING: pc starts from 0, so the first advance is exactly 2^NP cycles after the first cycle in which run=1 is sampled.
- Leaving RUNNING: pc is cleared on the same edge; no partial count is retained.
- Advance rules:
  - Up: sel ← (sel = NSTATES-1) ? 0 : sel+1.
  - Down: sel ← (sel = 0) ? NSTATES-1 : sel-1.
  - dir is sampled on the advancing edge only; a dir change between advances affects only the next advance.
- sel never leaves the range 0..NSTATES-1. The upper bits of the 4-bit sel are 0 when NSTATES ≤ 8 and so on.
- tick and wrap are registered. They are asserted for exactly one cycle after each advance edge and are 0 otherwise.
- Reset values (asynchronous, immediate):
  - sel=0, tick=0, wrap=0, pc=0, FSM=STOPPED.
  - step_q=1, so a step held high across reset release does not produce an advance.
- Reset mid-operation: all outputs return to their reset values in the same cycle, regardless of pc or FSM state. tick or wrap pulses in flight are cancelled.

## Timing
- Run-mode period: exactly 2^NP cycles between consecutive tick pulses, with no jitter, for as long as run stays 1.
- Single-step latency: step rising is sampled at edge k; sel and tick update at edge k. tick is high from edge k to edge k+1.
- step held high for many cycles produces exactly one advance; step must return low for ≥1 cycle before re-arming.
- Simultaneous run 0→1 and step rising at the same edge: the FSM enters RUNNING and the step is ignored (no advance).
- Simultaneous run 1→0 and a prescaler terminal count at the same edge: the advance is suppressed, the FSM enters STOPPED and pc=0.
- Inputs run, dir and step are synchronous to clk; no internal synchronizers.

## Test plan
- Reset/idle: NP=1, NSTATES=4, rst pulse, run=0, step=0 for 10 cycles -> sel=0, tick=0, wrap=0 throughout.
- Free-run up: NP=1, NSTATES=4, run=1, dir=0 -> sel sequence 0,1,2,3,0,1 changing every 2 cycles. tick pulses every 2 cycles; wrap pulses only on 3→0. First change occurs 2 cycles after run is sampled high.
- Free-run down with direction change: NP=2, NSTATES=3, start up, set dir=1 after sel=2 -> next advances give 1,0,2. wrap is asserted on 0→2. Advance spacing stays 4 cycles.
- Single-step: NP=4, run=0, step high for 5 cycles, low for 2, high for 1 -> exactly two advances (sel 0→1→2), each with a one-cycle tick. No advance while step stays high.
- Mode edges:
  - With NP=2, drop run at the terminal-count edge -> no advance and pc cleared. Re-raising run gives the first tick 4 cycles later.
  - run and step rising together -> no extra advance.
- Reset mid-run and across step: assert rst while sel=2 and tick=1 -> sel=0 and tick=0 immediately. Release rst with step held high -> no advance until step falls and rises again.

Source files
------------

// File: rtl/step_seq.sv
// Prescaled modulo-NSTATES index sequencer driving the LED mux select.
// Free-running or single-step advance, up/down, with one-cycle tick/wrap pulses.
module step_seq #(
  parameter int NP      = 22,
  parameter int NSTATES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  output logic [3:0] sel,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} mode_t;

  localparam logic [3:0]    LAST   = 4'(NSTATES - 1);
  localparam logic [NP-1:0] PC_ONE = 1;

  mode_t         state, state_nx;
  logic          running;
  logic [NP-1:0] pc;
  logic          step_q;
  logic          adv;
  logic          at_bound;
  logic [3:0]    sel_nx;

  // mode FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOPPED;
    else     state <= state_nx;
  end

  // mode FSM: next state follows the sampled run level
  always_comb begin
    state_nx = state;
    if (run) state_nx = RUNNING;
    else     state_nx = STOPPED;
  end

  // mode FSM: outputs. Any advance needs run to agree with the current mode,
  // so a mode change on the same edge swallows a step or a terminal count.
  always_comb begin
    running = 1'b0;
    adv     = 1'b0;
    case (state)
      RUNNING: begin
        running = 1'b1;
        adv     = run & (&pc);
      end
      default: adv = step & ~step_q & ~run;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pc <= '0;
    else if (running && run)  pc <= pc + PC_ONE;
    else                      pc <= '0;
  end

  always_comb begin
    at_bound = dir ? (sel == 4'd0) : (sel == LAST);
    sel_nx   = sel;
    if (adv) begin
      if (dir) sel_nx = at_bound ? LAST : sel - 4'd1;
      else     sel_nx = at_bound ? 4'd0 : sel + 4'd1;
    end
  end

  // step_q resets high so a step held across reset release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= 4'd0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
      step_q <= 1'b1;
    end else begin
      sel    <= sel_nx;
      tick   <= adv;
      wrap   <= adv & at_bound;
      step_q <= step;
    end
  end

endmodule

// File: tb/tb_step_seq.sv
// Scoreboard bench for step_seq: three configurations share clk/rst;
// stimulus queues expected (sel, wrap, cycle) per advance, monitors pop on tick.
module tb_step_seq;

  typedef struct {
    logic [3:0] sel;
    logic       wrap;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_a = 0, dir_a = 0, step_a = 0;
  logic       run_b = 0, dir_b = 0, step_b = 0;
  logic       run_c = 0, dir_c = 0, step_c = 0;
  logic [3:0] sel_a, sel_b, sel_c;
  logic       tick_a, tick_b, tick_c;
  logic       wrap_a, wrap_b, wrap_c;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  step_seq #(.NP(1), .NSTATES(4)) u_a (
    .clk(clk), .rst(rst), .run(run_a), .dir(dir_a), .step(step_a),
    .sel(sel_a), .tick(tick_a), .wrap(wrap_a));
  step_seq #(.NP(2), .NSTATES(3)) u_b (
    .clk(clk), .rst(rst), .run(run_b), .dir(dir_b), .step(step_b),
    .sel(sel_b), .tick(tick_b), .wrap(wrap_b));
  step_seq #(.NP(4), .NSTATES(4)) u_c (
    .clk(clk), .rst(rst), .run(run_c), .dir(dir_c), .step(step_c),
    .sel(sel_c), .tick(tick_c), .wrap(wrap_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [3:0] s, input logic w);
    chk({nm, "_sel"},  int'(s), int'(e.sel));
    chk({nm, "_wrap"}, int'(w), int'(e.wrap));
    chk({nm, "_cyc"},  cyc,     e.cyc);
  endtask

  task automatic unexpected(input string nm, input logic [3:0] s);
    total++;
    bad++;
    $display("FAIL %s_tick: unexpected tick, sel=%0d, want no tick (cyc %0d)", nm, s, cyc);
  endtask

  function automatic exp_t mk(input int s, input bit w, input int c);
    exp_t e;
    e.sel  = 4'(s);
    e.wrap = w;
    e.cyc  = c;
    return e;
  endfunction

  // wait for edge c and move 1 time unit past it
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (tick_a) begin
      if (qa.size() == 0) unexpected("a", sel_a);
      else cmp("a", qa.pop_front(), sel_a, wrap_a);
    end else chk("a_wrap_idle", int'(wrap_a), 0);
  end

  always @(negedge clk) if (!rst) begin
    if (tick_b) begin
      if (qb.size() == 0) unexpected("b", sel_b);
      else cmp("b", qb.pop_front(), sel_b, wrap_b);
    end else chk("b_wrap_idle", int'(wrap_b), 0);
  end

  always @(negedge clk) if (!rst) begin
    if (tick_c) begin
      if (qc.size() == 0) unexpected("c", sel_c);
      else cmp("c", qc.pop_front(), sel_c, wrap_c);
    end else chk("c_wrap_idle", int'(wrap_c), 0);
  end

  initial begin
    int n, m, k, p;

    // reset and idle
    #2;
    chk("rst_sel_a", int'(sel_a), 0);
    chk("rst_tick_a", int'(tick_a), 0);
    chk("rst_wrap_a", int'(wrap_a), 0);
    chk("rst_sel_b", int'(sel_b), 0);
    at(2);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_sel_a", int'(sel_a), 0);
      chk("idle_tick_a", int'(tick_a), 0);
    end

    // free-run up, NP=1 NSTATES=4
    n = cyc;
    run_a = 1'b1;
    qa.push_back(mk(1, 0, n + 3));
    qa.push_back(mk(2, 0, n + 5));
    qa.push_back(mk(3, 0, n + 7));
    qa.push_back(mk(0, 1, n + 9));
    qa.push_back(mk(1, 0, n + 11));
    at(n + 11);
    run_a = 1'b0;

    // free-run NP=2 NSTATES=3, up then down
    n = cyc;
    run_b = 1'b1;
    qb.push_back(mk(1, 0, n + 5));
    qb.push_back(mk(2, 0, n + 9));
    at(n + 9);
    dir_b = 1'b1;
    qb.push_back(mk(1, 0, n + 13));
    qb.push_back(mk(0, 0, n + 17));
    qb.push_back(mk(2, 1, n + 21));
    // drop run so it is sampled at the terminal-count edge n+25
    at(n + 24);
    run_b = 1'b0;
    at(n + 27);
    m = cyc;
    run_b = 1'b1;
    qb.push_back(mk(1, 0, m + 5));
    at(m + 5);
    run_b = 1'b0;

    // run and step rising together: no advance
    at(m + 7);
    k = cyc;
    run_b  = 1'b1;
    step_b = 1'b1;
    at(k + 2);
    run_b = 1'b0;
    at(k + 5);
    step_b = 1'b0;
    at(k + 7);
    chk("b_sel_after_runstep", int'(sel_b), 1);

    // single step, NP=4
    k = cyc;
    step_c = 1'b1;
    qc.push_back(mk(1, 0, k + 1));
    at(k + 5);
    step_c = 1'b0;
    at(k + 7);
    step_c = 1'b1;
    qc.push_back(mk(2, 0, k + 8));
    at(k + 8);
    step_c = 1'b0;
    at(k + 12);

    // reset mid-run while tick is high, then release with step held
    p = cyc;
    run_a = 1'b1;
    at(p + 3);
    chk("a_pre_rst_sel", int'(sel_a), 2);
    chk("a_pre_rst_tick", int'(tick_a), 1);
    rst    = 1'b1;
    run_a  = 1'b0;
    step_a = 1'b1;
    #1;
    chk("midrst_sel_a", int'(sel_a), 0);
    chk("midrst_tick_a", int'(tick_a), 0);
    chk("midrst_sel_b", int'(sel_b), 0);
    chk("midrst_sel_c", int'(sel_c), 0);
    at(p + 5);
    rst = 1'b0;
    at(p + 9);
    step_a = 1'b0;
    at(p + 11);
    step_a = 1'b1;
    qa.push_back(mk(1, 0, p + 12));
    at(p + 12);
    step_a = 1'b0;
    at(p + 16);

    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    chk("c_pending", qc.size(), 0);
    chk("final_sel_a", int'(sel_a), 1);
    chk("final_sel_c", int'(sel_c), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
